spi_slave: RTL
==============

SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 clk  input  1  single system clock; all state on rising edge.
REQ-002 reset_n  input  1  asynchronous, active-low reset.
REQ-003 ss  input  1  SPI select, active-low, from master.
REQ-004 sck  input  1  SPI clock, mode 0, max frequency clk/4.
REQ-005 mosi  input  1  serial data from master, LSB first.
REQ-006 miso  output  1  serial data to master, LSB first.
REQ-007 rx_data  output  16  last complete word received on mosi.
REQ-008 rx_valid  output  1  rx_data holds an unconsumed word.
REQ-009 rx_ready  input  1  consumer takes rx_data when rx_valid & rx_ready.
REQ-010 rx_overrun  output  1  sticky; a word was overwritten before being consumed.
REQ-011 tx_data  input  16  word to send on miso.
REQ-012 tx_valid  input  1  tx_data offered.
REQ-013 tx_ready  output  1  holding register empty; word accepted when tx_valid & tx_ready.
REQ-014 tx_underrun  output  1  one-clk pulse: frame began with no word held.
REQ-015 busy  output  1  frame in progress (synchronized ss low).

Function
REQ-016 ss, sck, mosi SHALL each pass a 2-flop synchronizer; sck edges detected from synchronized value vs. its previous value.
REQ-017 State machine SHALL have states IDLE, SHIFT, DONE.
REQ-018 IDLE -> SHIFT on synchronized ss falling: bit counter <= 0; shift-out <= holding word if held (marked in-flight) else 16'hFFFF with tx_underrun pulse.
REQ-019 miso SHALL equal shift-out bit 0 at all times in SHIFT/DONE, and 1 in IDLE.
REQ-020 SHIFT: each synchronized sck rise SHALL do rx_sh <= {mosi, rx_sh[15:1]} and increment bit counter; each synchronized sck fall SHALL do shift-out <= {1, shift-out[15:1]}.
REQ-021 16th sck rise -> DONE; next clk rx_data <= rx_sh, rx_valid <= 1; in-flight holding word released (tx_ready <= 1).
REQ-022 If rx_valid is 1 and not consumed on the load clk, rx_data SHALL be overwritten and rx_overrun set.
REQ-023 Load and consume on the same clk: new word wins, rx_valid stays 1, no overrun.
REQ-024 DONE -> IDLE on synchronized ss rising; further sck edges in DONE SHALL be ignored.
REQ-025 ss rising in SHIFT (abort, <16 bits): partial word discarded, rx_valid unchanged, in-flight holding word retained for next frame, -> IDLE.
REQ-026 Holding register is one entry; tx_ready = !held; tx_valid ignored while tx_ready is 0.
REQ-027 rx_overrun SHALL clear only on reset.
REQ-028 Latency: rx_valid rises 4 clk after the physical 16th sck rise (2 sync + 1 detect + 1 load).

Reset
REQ-029 reset_n low SHALL force IDLE, miso=1, rx_data=16'h0000, rx_valid=0, rx_overrun=0, tx_ready=1, tx_underrun=0, busy=0, counters/shift registers cleared, synchronizers to ss=1, sck=0, mosi=1.
REQ-030 Reset during a frame SHALL discard the frame and held tx word; after release block waits for a fresh ss falling edge.

Configuration
REQ-031 Macro SPI_SLAVE_DROP_IDLE_EN defined: received words equal to 16'hFFFF (master idle fill) SHALL be discarded without touching rx_data, rx_valid or rx_overrun.
REQ-032 Macro undefined: every complete word, including 16'hFFFF, SHALL be delivered.

Verification
REQ-033 Held tx 16'hA5C3, frame with mosi 16'h1234, sck=clk/4 -> master sees 16'hA5C3 LSB first; rx_data=16'h1234, rx_valid=1, tx_ready=1.
REQ-034 Two frames 16'h0001, 16'h0002, rx_ready=0 -> rx_data=16'h0002, rx_overrun=1.
REQ-035 No tx held at ss fall -> tx_underrun one-clk pulse, miso reads 16'hFFFF.
REQ-036 ss deasserted after 9 bits, then full frame 16'h00FF, held tx 16'h5555 -> only 16'h00FF delivered; 16'h5555 sent in second frame.
REQ-037 mosi 16'hFFFF frame -> delivered without macro; rx_valid stays 0 with SPI_SLAVE_DROP_IDLE_EN.
REQ-038 reset_n low at bit 7 -> all outputs at reset values; next full frame 16'hBEEF received correctly.

Source files
------------

// File: rtl/spi_slave.sv
// SPI mode-0 slave with 16-bit LSB-first words, rx/tx ready-valid handshakes and 2-flop input sync.
// Optional build macro SPI_SLAVE_DROP_IDLE_EN: discard received 16'hFFFF words (master idle fill).
//
// state | meaning
// IDLE  | ss high, miso parked at 1, waiting for ss falling edge
// SHIFT | frame active, shifting on synchronized sck edges
// DONE  | 16 bits received, further sck edges ignored until ss rises
module spi_slave (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ss,
  input  logic        sck,
  input  logic        mosi,
  output logic        miso,
  output logic [15:0] rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        rx_overrun,
  input  logic [15:0] tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        tx_underrun,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e      state_q, state_d;

  logic        ss_s1_q, ss_s2_q, ss_prev_q;
  logic        sck_s1_q, sck_s2_q, sck_prev_q;
  logic        mosi_s1_q, mosi_s2_q;

  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] rx_sh_q, rx_sh_d;
  logic [15:0] tx_sh_q, tx_sh_d;
  logic        load_q, load_d;
  logic [15:0] hold_q, hold_d;
  logic        held_q, held_d;
  logic        inflight_q, inflight_d;
  logic [15:0] rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        rx_overrun_q, rx_overrun_d;
  logic        tx_underrun_q, tx_underrun_d;

  logic        ss_fall, sck_rise, sck_fall, keep_word;

  assign ss_fall  = !ss_s2_q && ss_prev_q;
  assign sck_rise = sck_s2_q && !sck_prev_q;
  assign sck_fall = !sck_s2_q && sck_prev_q;

`ifdef SPI_SLAVE_DROP_IDLE_EN
  assign keep_word = (rx_sh_q != 16'hFFFF);
`else
  assign keep_word = 1'b1;
`endif

  // Synchronizers park at the idle bus levels so reset never looks like an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ss_s1_q    <= 1'b1;
      ss_s2_q    <= 1'b1;
      ss_prev_q  <= 1'b1;
      sck_s1_q   <= 1'b0;
      sck_s2_q   <= 1'b0;
      sck_prev_q <= 1'b0;
      mosi_s1_q  <= 1'b1;
      mosi_s2_q  <= 1'b1;
    end else begin
      ss_s1_q    <= ss;
      ss_s2_q    <= ss_s1_q;
      ss_prev_q  <= ss_s2_q;
      sck_s1_q   <= sck;
      sck_s2_q   <= sck_s1_q;
      sck_prev_q <= sck_s2_q;
      mosi_s1_q  <= mosi;
      mosi_s2_q  <= mosi_s1_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      bit_cnt_q     <= 5'd0;
      rx_sh_q       <= 16'h0000;
      tx_sh_q       <= 16'hFFFF;
      load_q        <= 1'b0;
      hold_q        <= 16'h0000;
      held_q        <= 1'b0;
      inflight_q    <= 1'b0;
      rx_data_q     <= 16'h0000;
      rx_valid_q    <= 1'b0;
      rx_overrun_q  <= 1'b0;
      tx_underrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_sh_q       <= rx_sh_d;
      tx_sh_q       <= tx_sh_d;
      load_q        <= load_d;
      hold_q        <= hold_d;
      held_q        <= held_d;
      inflight_q    <= inflight_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      rx_overrun_q  <= rx_overrun_d;
      tx_underrun_q <= tx_underrun_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    rx_sh_d       = rx_sh_q;
    tx_sh_d       = tx_sh_q;
    load_d        = 1'b0;
    hold_d        = hold_q;
    held_d        = held_q;
    inflight_d    = inflight_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q;
    rx_overrun_d  = rx_overrun_q;
    tx_underrun_d = 1'b0;

    if (tx_valid && !held_q) begin
      hold_d = tx_data;
      held_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d   = SHIFT;
          bit_cnt_d = 5'd0;
          if (held_q) begin
            tx_sh_d    = hold_q;
            inflight_d = 1'b1;
          end else begin
            tx_sh_d       = 16'hFFFF;
            tx_underrun_d = 1'b1;
          end
        end
      end
      SHIFT: begin
        // Abort keeps the held word so it is resent in the next frame.
        if (ss_s2_q) begin
          state_d    = IDLE;
          inflight_d = 1'b0;
        end else if (sck_rise) begin
          rx_sh_d   = {mosi_s2_q, rx_sh_q[15:1]};
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd15) begin
            state_d = DONE;
            load_d  = 1'b1;
          end
        end else if (sck_fall) begin
          tx_sh_d = {1'b1, tx_sh_q[15:1]};
        end
      end
      DONE: begin
        if (ss_s2_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (load_q && keep_word) begin
      rx_data_d  = rx_sh_q;
      rx_valid_d = 1'b1;
      if (rx_valid_q && !rx_ready) rx_overrun_d = 1'b1;
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end

    if (load_q && inflight_q) begin
      held_d     = 1'b0;
      inflight_d = 1'b0;
    end
  end

  assign miso        = (state_q == IDLE) ? 1'b1 : tx_sh_q[0];
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign rx_overrun  = rx_overrun_q;
  assign tx_ready    = !held_q;
  assign tx_underrun = tx_underrun_q;
  assign busy        = (state_q != IDLE);

endmodule
